// File: rtl/mem_trace_pkg.sv
// Shared types and helpers for the data-memory model and its retire-trace recorder.
package mem_trace_pkg;

  localparam logic KIND_MEM = 1'b0;
  localparam logic KIND_GRF = 1'b1;

  typedef struct packed {
    logic        kind;
    logic [31:0] cycle;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  // Replace only the byte lanes selected by byteen.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byteen);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[i*8 +: 8] = byteen[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_trace_unit_fifo.sv
// Two-write, one-read ring buffer for trace records; port 0 has priority for free slots.
module trace_fifo
  import mem_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push0,
  input  logic [REC_W-1:0]          rec0,
  input  logic                      push1,
  input  logic [REC_W-1:0]          rec1,
  input  logic                      pop,
  output logic [REC_W-1:0]          head,
  output logic                      valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [REC_W-1:0] ring [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             acc0;
  logic             acc1;
  logic [AW+1:0]    free;

  assign valid  = (count != '0);
  assign pop_ok = pop & valid;
  assign head   = ring[rd_ptr];

  // A pop on the same edge frees its slot for an incoming push.
  assign free = DEPTH_W - (AW+2)'(count) + (AW+2)'(pop_ok);
  assign acc0 = push0 & (free != '0);
  assign acc1 = push1 & (free > (AW+2)'(acc0));
  assign drop = (push0 & ~acc0) | (push1 & ~acc1);

  always_ff @(posedge clk) begin
    if (acc0) ring[wr_ptr] <= rec0;
    if (acc1) ring[wr_ptr + AW'(acc0)] <= rec1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(acc0) + AW'(acc1);
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(acc0) + (AW+1)'(acc1) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/mem_trace_unit.sv
// Byte-enabled data memory for the pipeline benches, recording memory and
// register-file writes as cycle-stamped records on a valid/ready stream.
module mem_trace_unit
  import mem_trace_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int RD_LAT      = 0,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   m_data_addr,
  input  logic [31:0]                   m_data_wdata,
  input  logic [3:0]                    m_data_byteen,
  input  logic [31:0]                   m_inst_addr,
  output logic [31:0]                   m_data_rdata,
  input  logic                          w_grf_we,
  input  logic [4:0]                    w_grf_addr,
  input  logic [31:0]                   w_grf_wdata,
  input  logic [31:0]                   w_inst_addr,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic                          trace_kind,
  output logic [31:0]                   trace_cycle,
  output logic [31:0]                   trace_pc,
  output logic [31:0]                   trace_addr,
  output logic [31:0]                   trace_data,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count,
  output logic                          overflow,
  output logic                          addr_err
);

  localparam int MAW = $clog2(DEPTH_WORDS);

  logic [31:0]    mem [DEPTH_WORDS];
  logic [29:0]    idx;
  logic           in_range;
  logic           wr_req;
  logic           mem_ev;
  logic           grf_ev;
  logic [31:0]    cur_word;
  logic [31:0]    merged;
  logic [31:0]    cycle_cnt;
  trace_rec_t     mem_rec;
  trace_rec_t     grf_rec;
  trace_rec_t     head_rec;
  logic [REC_W-1:0] head_bits;
  logic           fifo_drop;

  assign idx      = m_data_addr[31:2];
  assign in_range = ({2'b00, idx} < 32'(DEPTH_WORDS));
  assign wr_req   = (m_data_byteen != 4'b0000);
  assign mem_ev   = wr_req & in_range & ~reset;
  assign grf_ev   = w_grf_we & (w_grf_addr != 5'd0) & ~reset;
  assign cur_word = in_range ? mem[idx[MAW-1:0]] : 32'h0;
  assign merged   = merge_lanes(cur_word, m_data_wdata, m_data_byteen);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (mem_ev) begin
      mem[idx[MAW-1:0]] <= merged;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_rd_comb
      assign m_data_rdata = cur_word;
    end else begin : g_rd_reg
      // Nonblocking update samples the array before this edge's write lands.
      always_ff @(posedge clk) begin
        if (reset) m_data_rdata <= 32'h0;
        else       m_data_rdata <= cur_word;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= 32'h0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_comb begin
    mem_rec       = '0;
    mem_rec.kind  = KIND_MEM;
    mem_rec.cycle = cycle_cnt;
    mem_rec.pc    = m_inst_addr;
    mem_rec.addr  = {m_data_addr[31:2], 2'b00};
    mem_rec.data  = merged;
    grf_rec       = '0;
    grf_rec.kind  = KIND_GRF;
    grf_rec.cycle = cycle_cnt;
    grf_rec.pc    = w_inst_addr;
    grf_rec.addr  = {27'b0, w_grf_addr};
    grf_rec.data  = w_grf_wdata;
  end

  trace_fifo #(.DEPTH(TRACE_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (mem_ev),
    .rec0  (mem_rec),
    .push1 (grf_ev),
    .rec1  (grf_rec),
    .pop   (trace_valid & trace_ready),
    .head  (head_bits),
    .valid (trace_valid),
    .count (trace_count),
    .drop  (fifo_drop)
  );

  assign head_rec    = head_bits;
  assign trace_kind  = head_rec.kind;
  assign trace_cycle = head_rec.cycle;
  assign trace_pc    = head_rec.pc;
  assign trace_addr  = head_rec.addr;
  assign trace_data  = head_rec.data;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (fifo_drop)             overflow <= 1'b1;
      if (wr_req && !in_range)   addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_trace_unit.sv
// Directed bench for mem_trace_unit: lane merge, event ordering, overflow,
// full push/pop, address errors and mid-stream reset.
module tb_mem_trace_unit;
  import mem_trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
  logic [3:0]  m_data_byteen;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata, w_inst_addr;
  logic        trace_valid, trace_ready, trace_kind;
  logic [31:0] trace_cycle, trace_pc, trace_addr, trace_data;
  logic [4:0]  trace_count;
  logic        overflow, addr_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cyc = 0;
  trace_rec_t  exp_q[$];

  always #5 clk = ~clk;

  mem_trace_unit #(.DEPTH_WORDS(4096), .RD_LAT(0), .TRACE_DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
    .m_data_rdata(m_data_rdata),
    .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
    .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_kind(trace_kind), .trace_cycle(trace_cycle),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_count(trace_count), .overflow(overflow), .addr_err(addr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // cyc tracks the DUT counter value during the current cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  endtask

  task automatic idle_inputs();
    m_data_byteen = 4'b0000;
    w_grf_we      = 1'b0;
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] pc);
    m_data_addr = a; m_data_wdata = d; m_data_byteen = be; m_inst_addr = pc;
  endtask

  task automatic grf_write(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    w_grf_we = 1'b1; w_grf_addr = r; w_grf_wdata = d; w_inst_addr = pc;
  endtask

  task automatic expect_rec(input logic k, input logic [31:0] c, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] d);
    trace_rec_t r;
    r.kind = k; r.cycle = c; r.pc = pc; r.addr = a; r.data = d;
    exp_q.push_back(r);
  endtask

  // Compare the head against the oldest expected record, then pop it.
  task automatic drain(input int n);
    trace_rec_t r;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        check("drain_model_empty", 32'(exp_q.size()), 32'd1);
        return;
      end
      r = exp_q.pop_front();
      check("rec_valid", 32'(trace_valid), 32'd1);
      check("rec_kind",  32'(trace_kind),  32'(r.kind));
      check("rec_cycle", trace_cycle, r.cycle);
      check("rec_pc",    trace_pc,    r.pc);
      check("rec_addr",  trace_addr,  r.addr);
      check("rec_data",  trace_data,  r.data);
      trace_ready = 1'b1;
      step();
      trace_ready = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; trace_ready = 1'b0;
    m_data_addr = 0; m_data_wdata = 0; m_inst_addr = 0;
    w_grf_addr = 0; w_grf_wdata = 0; w_inst_addr = 0;
    idle_inputs();
    step(); step();
    reset = 1'b0;

    check("rst_valid", 32'(trace_valid), 32'd0);
    check("rst_count", 32'(trace_count), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_aerr",  32'(addr_err), 32'd0);
    m_data_addr = 32'h10;
    #1 check("rst_rdata", m_data_rdata, 32'h0);

    // Byte-lane merge
    mem_write(32'h10, 32'h11223344, 4'b1111, 32'h1000);
    expect_rec(KIND_MEM, cyc, 32'h1000, 32'h10, 32'h11223344);
    step();
    mem_write(32'h12, 32'hAABBCCDD, 4'b0100, 32'h1004);
    expect_rec(KIND_MEM, cyc, 32'h1004, 32'h10, 32'h11BB3344);
    step();
    idle_inputs();
    m_data_addr = 32'h10;
    #1 check("merge_rdata", m_data_rdata, 32'h11BB3344);
    check("merge_count", 32'(trace_count), 32'd2);
    drain(2);
    check("merge_empty", 32'(trace_valid), 32'd0);

    // Same-cycle memory + register events
    mem_write(32'h20, 32'hCAFEF00D, 4'b1111, 32'h3004);
    grf_write(5'd5, 32'h12345678, 32'h3000);
    expect_rec(KIND_MEM, cyc, 32'h3004, 32'h20, 32'hCAFEF00D);
    expect_rec(KIND_GRF, cyc, 32'h3000, 32'h5, 32'h12345678);
    step();
    idle_inputs();
    check("dual_count", 32'(trace_count), 32'd2);
    drain(2);
    grf_write(5'd0, 32'hFFFFFFFF, 32'h3008);
    step();
    idle_inputs();
    check("r0_count", 32'(trace_count), 32'd0);
    check("r0_valid", 32'(trace_valid), 32'd0);

    // Speculative out-of-range read, then out-of-range write
    m_data_addr = 32'h8000_0000;
    step();
    check("spec_aerr",  32'(addr_err), 32'd0);
    check("spec_rdata", m_data_rdata, 32'h0);
    mem_write(32'h4000, 32'hDEADBEEF, 4'b1111, 32'h300C);
    step();
    idle_inputs();
    check("oor_aerr",  32'(addr_err), 32'd1);
    check("oor_count", 32'(trace_count), 32'd0);
    m_data_addr = 32'h4000;
    #1 check("oor_rdata", m_data_rdata, 32'h0);
    m_data_addr = 32'h0;
    #1 check("oor_word0", m_data_rdata, 32'h0);

    // Full FIFO with simultaneous pop and push
    for (int i = 1; i <= 16; i++) begin
      grf_write(5'(i), 32'h100 + 32'(i), 32'h5000 + 32'(4*i));
      expect_rec(KIND_GRF, cyc, 32'h5000 + 32'(4*i), 32'(i), 32'h100 + 32'(i));
      step();
    end
    idle_inputs();
    check("full_count", 32'(trace_count), 32'd16);
    check("full_ovf",   32'(overflow), 32'd0);
    begin
      trace_rec_t r;
      r = exp_q.pop_front();
      check("fpp_head_data", trace_data, r.data);
    end
    trace_ready = 1'b1;
    grf_write(5'd17, 32'h200, 32'h6000);
    expect_rec(KIND_GRF, cyc, 32'h6000, 32'd17, 32'h200);
    step();
    idle_inputs();
    trace_ready = 1'b0;
    check("fpp_count", 32'(trace_count), 32'd16);
    check("fpp_ovf",   32'(overflow), 32'd0);
    drain(16);
    check("fpp_empty", 32'(trace_count), 32'd0);

    // Overflow: 15 queued, then a dual-event cycle, then one more event
    for (int i = 1; i <= 15; i++) begin
      grf_write(5'(i), 32'h300 + 32'(i), 32'h7000 + 32'(4*i));
      expect_rec(KIND_GRF, cyc, 32'h7000 + 32'(4*i), 32'(i), 32'h300 + 32'(i));
      step();
    end
    check("ovf_pre_count", 32'(trace_count), 32'd15);
    mem_write(32'h40, 32'h0BADF00D, 4'b1111, 32'h4444);
    grf_write(5'd7, 32'h77, 32'h4440);
    expect_rec(KIND_MEM, cyc, 32'h4444, 32'h40, 32'h0BADF00D);
    step();
    idle_inputs();
    check("ovf_count", 32'(trace_count), 32'd16);
    check("ovf_flag",  32'(overflow), 32'd1);
    grf_write(5'd9, 32'h99, 32'h4448);
    step();
    idle_inputs();
    check("ovf_drop_count", 32'(trace_count), 32'd16);
    drain(16);
    check("ovf_empty",  32'(trace_count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset with records queued
    for (int i = 1; i <= 5; i++) begin
      grf_write(5'(i), 32'(i), 32'h8000);
      step();
    end
    idle_inputs();
    check("mid_count", 32'(trace_count), 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("mid_valid", 32'(trace_valid), 32'd0);
    check("mid_count0", 32'(trace_count), 32'd0);
    check("mid_ovf",  32'(overflow), 32'd0);
    check("mid_aerr", 32'(addr_err), 32'd0);
    m_data_addr = 32'h10;
    #1 check("mid_rdata10", m_data_rdata, 32'h0);
    m_data_addr = 32'h20;
    #1 check("mid_rdata20", m_data_rdata, 32'h0);
    grf_write(5'd3, 32'h33, 32'h9000);
    expect_rec(KIND_GRF, 32'd0, 32'h9000, 32'd3, 32'h33);
    step();
    idle_inputs();
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_trace_unit.md
# mem_trace_unit

Parametrised, byte-enabled data-memory model with a built-in retire-trace recorder for the MIPS pipeline benches. It serves the core's data port (address, write data, byte enables, read data). Each cycle it captures memory writes and register-file writes as timestamped events. Events drain through a valid/ready stream to the bench's golden-model comparator, replacing ad-hoc per-bench display statements.

## Interface
- `DEPTH_WORDS`, default 4096: data-memory depth in 32-bit words; power of two.
- `RD_LAT`, default 0: read latency, either 0 (combinational) or 1 (registered).
- `TRACE_DEPTH`, default 16: trace FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `m_data_addr`  in  32  byte address from the core.
- `m_data_wdata`  in  32  write data, byte lanes already aligned.
- `m_data_byteen`  in  4  per-lane write enable; nonzero means write.
- `m_inst_addr`  in  32  PC of the instruction in the memory stage.
- `m_data_rdata`  out  32  read data for the word at `m_data_addr`.
- `w_grf_we`  in  1  register-file write enable.
- `w_grf_addr`  in  5  destination register.
- `w_grf_wdata`  in  32  register-file write data.
- `w_inst_addr`  in  32  PC of the instruction in the writeback stage.
- `trace_valid`  out  1  trace record available.
- `trace_ready`  in  1  consumer accepts the record.
- `trace_kind`  out  1  record type: 0 = memory write, 1 = register write.
- `trace_cycle`  out  32  cycle stamp of the record.
- `trace_pc`  out  32  PC of the instruction that produced the record.
- `trace_addr`  out  32  word-aligned byte address, or `{27'b0, reg}` for register writes.
- `trace_data`  out  32  merged memory word, or the register data.
- `trace_count`  out  $clog2(TRACE_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: at least one event was dropped.
- `addr_err`  out  1  sticky: an access fell outside the memory range.

## Operation
- **Word index:** `idx = m_data_addr[31:2]`. An access is in range when `idx < DEPTH_WORDS`.
- **Write:** when `byteen` is nonzero and the access is in range, replace exactly the enabled lanes of `mem[idx]`; other lanes keep their old values. Out-of-range writes are ignored and set `addr_err`.
- **Read:** returns `mem[idx]`, or 0 when out of range. An out-of-range read with `byteen == 0` does not set `addr_err` (the core reads speculatively).
- **Cycle counter:** 32 bits, cleared by reset, +1 on every non-reset edge, wraps at 2^32.
- **Memory-write event:** raised on a cycle where `byteen` is nonzero and the access is in range. Record fields:
  - kind 0
  - stamp = counter
  - pc = `m_inst_addr`
  - addr = `m_data_addr & ~3`
  - data = the merged word
- **Register-write event:** raised when `w_grf_we` is 1 and `w_grf_addr` is not 0. Record fields:
  - kind 1
  - same stamp as any memory event in the cycle
  - pc = `w_inst_addr`
- **Same-cycle events:** both are enqueued in the same cycle, memory event first.
- **Free slots:** `free = TRACE_DEPTH - count + pop`, where `pop = trace_valid & trace_ready`. A push into a full FIFO is allowed in the same cycle as a pop.
- **Overflow:**
  - If `free` is 1 and both events occur, the memory event is kept, the register event is dropped and `overflow` is set.
  - If `free` is 0, every event that cycle is dropped and `overflow` is set.
- **Sticky flags:** `overflow` and `addr_err` clear only on reset.
- **Reset:** all memory words, the counter, the FIFO, both flags and `trace_valid` go to 0. Events and writes on reset cycles are ignored.

## Timing
- **RD_LAT = 0:** `m_data_rdata` is combinational from `addr` and the current array. A same-cycle write becomes visible after the edge.
- **RD_LAT = 1:** `m_data_rdata` is registered, sampled at the edge from the pre-write array (read-before-write). Reset value 0.
- **Trace latency:** an event pushed at edge N appears on `trace_*` after edge N when the FIFO was empty (1-cycle latency).
- **Stream rules:**
  - Output fields hold stable while `trace_valid` is high and `trace_ready` is low.
  - `trace_valid` never drops without a pop.
  - `trace_ready` is allowed to be asserted while `trace_valid` is low (no effect).
- **Occupancy:** `trace_count` changes by -1..+2 per edge.
- **Reset mid-stream:** the FIFO empties at the edge and `trace_valid` is 0 on the next cycle.

## Structure
- **Package `mem_trace_pkg`:**
  - `KIND_MEM` and `KIND_GRF` constants.
  - Packed `trace_rec_t` struct: kind, cycle, pc, addr, data (129 bits).
  - Lane-merge function taking old word, new word and byteen.
- **Sub-module `trace_fifo`:**
  - Two write ports (priority port 0), one read port.
  - Power-of-two ring buffer with wrap-around pointers.
  - Pop-before-push full rule.
  - `count` output.
- **Top level:** memory array, read path, counter, event generation, flags.

## Test plan
- **Byte-lane merge:** after reset, write 0x11223344 with byteen 1111 to addr 0x10, then 0xAABBCCDD with byteen 0100 to addr 0x12. Read of 0x10 returns 0x11BB3344. Two kind-0 records, data 0x11223344 then 0x11BB3344, addr 0x10.
- **Same-cycle ordering:** a memory write (pc 0x3004) and a write to $5 (pc 0x3000) in one cycle. Two records with the same stamp: kind 0 first, then kind 1 with addr 5. A write to $0 produces no record.
- **Overflow:** hold `trace_ready` low, TRACE_DEPTH=16. Push 15 events, then one dual-event cycle. Count is 16, the memory event is kept, `overflow` is 1. A further event with no pop is dropped, count stays 16.
- **Full push/pop:** FIFO full and `trace_ready` high with one new event. Count stays 16, `overflow` stays 0, records leave in FIFO order.
- **Address error:** write to `DEPTH_WORDS*4` sets `addr_err`, modifies no memory and emits no record. A read of the same address returns 0.
- **Reset mid-stream:** reset asserted with 5 records queued. The next cycle shows `trace_valid` 0, count 0, both flags 0, the cycle counter restarts at 0 and memory reads return 0.
